// File: rtl/fight_data_control.sv
// Turn-based battle engine: loads both players' stats, alternates skill commits
// (p1 by keys, p2 by LFSR pick), animates each hit and declares the KO winner.
// Optional critical hits are compiled in with the FIGHT_CRIT_EN macro.
module fight_data_control #(
  parameter int unsigned ANIM_CYCLES = 100,
  parameter logic [7:0]  LFSR_SEED   = 8'h5A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] scene_state,
  input  logic       key_U,
  input  logic       key_D,
  input  logic       key_C,
  input  logic [7:0] p1_pokemon_hp,
  input  logic [7:0] p1_pokemon_speed,
  input  logic [7:0] p1_skill_1_damage,
  input  logic [7:0] p1_skill_2_damage,
  input  logic [7:0] p1_skill_3_damage,
  input  logic [7:0] p2_pokemon_hp,
  input  logic [7:0] p2_pokemon_speed,
  input  logic [7:0] p2_skill_1_damage,
  input  logic [7:0] p2_skill_2_damage,
  input  logic [7:0] p2_skill_3_damage,
  output logic [7:0] p1_cur_hp,
  output logic [7:0] p2_cur_hp,
  output logic [1:0] p1_cursor,
  output logic       turn,
  output logic [1:0] last_skill,
  output logic [7:0] last_damage,
  output logic       last_crit,
  output logic       anim_busy,
  output logic       fight_over,
  output logic [1:0] winner
);

  localparam int          DATA_W    = 8;
  localparam logic [26:0] ANIM_LAST = 27'(ANIM_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, P1_SEL, P2_SEL, ATTACK, CHECK, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        lfsr;
  logic [26:0]       anim_cnt;
  logic              in_fight, abort, commit, p2_attacks, anim_done;
  logic [1:0]        p2_pick, commit_skill;
  logic [DATA_W-1:0] base_dmg, eff_dmg, def_hp;

  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] hp,
                                               input logic [DATA_W-1:0] dmg);
    return (hp > dmg) ? hp - dmg : '0;
  endfunction

`ifdef FIGHT_CRIT_EN
  function automatic logic [DATA_W-1:0] sat_double(input logic [DATA_W-1:0] dmg);
    logic [DATA_W:0] dbl;
    dbl = {dmg, 1'b0};
    return dbl[DATA_W] ? '1 : dbl[DATA_W-1:0];
  endfunction

  logic crit_hit;
  assign crit_hit = (lfsr[7:5] == 3'b111);
  assign eff_dmg  = crit_hit ? sat_double(base_dmg) : base_dmg;
`else
  assign eff_dmg   = base_dmg;
  assign last_crit = 1'b0;
`endif

  always_comb begin
    in_fight   = (scene_state == 4'd3);
    abort      = (state != IDLE) && !in_fight;
    p2_attacks = (state == P2_SEL);
    case (lfsr[1:0])
      2'd0:    p2_pick = 2'd1;
      2'd1:    p2_pick = 2'd2;
      2'd2:    p2_pick = 2'd3;
      default: p2_pick = 2'd1;
    endcase
    commit_skill = p2_attacks ? p2_pick : p1_cursor;
    commit       = !abort && ((state == P1_SEL && key_C) || p2_attacks);
    case ({p2_attacks, commit_skill})
      3'b0_01: base_dmg = p1_skill_1_damage;
      3'b0_10: base_dmg = p1_skill_2_damage;
      3'b0_11: base_dmg = p1_skill_3_damage;
      3'b1_01: base_dmg = p2_skill_1_damage;
      3'b1_10: base_dmg = p2_skill_2_damage;
      3'b1_11: base_dmg = p2_skill_3_damage;
      default: base_dmg = '0;
    endcase
    def_hp    = turn ? p1_cur_hp : p2_cur_hp;
    anim_done = (anim_cnt == ANIM_LAST);
  end

  // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_fight) state_nxt = LOAD;
        LOAD:    state_nxt = (p2_pokemon_speed > p1_pokemon_speed) ? P2_SEL : P1_SEL;
        P1_SEL:  if (key_C) state_nxt = ATTACK;
        P2_SEL:  state_nxt = ATTACK;
        ATTACK:  if (anim_done) state_nxt = CHECK;
        CHECK: begin
          if (def_hp == '0) state_nxt = DONE;
          else              state_nxt = turn ? P1_SEL : P2_SEL;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_cur_hp   <= '0;
      p2_cur_hp   <= '0;
      p1_cursor   <= 2'd1;
      turn        <= 1'b0;
      last_skill  <= 2'd0;
      last_damage <= '0;
      anim_busy   <= 1'b0;
      anim_cnt    <= '0;
      fight_over  <= 1'b0;
      winner      <= 2'd0;
`ifdef FIGHT_CRIT_EN
      last_crit   <= 1'b0;
`endif
    end else if (abort) begin
      // Leaving the scene keeps hp and result visible for the win scene
      anim_busy <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          p1_cur_hp   <= p1_pokemon_hp;
          p2_cur_hp   <= p2_pokemon_hp;
          p1_cursor   <= 2'd1;
          turn        <= (p2_pokemon_speed > p1_pokemon_speed);
          last_skill  <= 2'd0;
          last_damage <= '0;
          fight_over  <= 1'b0;
          winner      <= 2'd0;
`ifdef FIGHT_CRIT_EN
          last_crit   <= 1'b0;
`endif
        end
        P1_SEL: begin
          if (!key_C) begin
            if (key_U && !key_D && p1_cursor != 2'd1)
              p1_cursor <= p1_cursor - 2'd1;
            else if (key_D && !key_U && p1_cursor != 2'd3)
              p1_cursor <= p1_cursor + 2'd1;
          end
        end
        ATTACK: begin
          if (anim_done) anim_busy <= 1'b0;
          else           anim_cnt  <= anim_cnt + 27'd1;
        end
        CHECK: begin
          if (def_hp == '0) begin
            fight_over <= 1'b1;
            winner     <= turn ? 2'd2 : 2'd1;
          end else begin
            turn <= ~turn;
          end
        end
        default: ;
      endcase
      if (commit) begin
        if (p2_attacks) p1_cur_hp <= sat_sub(p1_cur_hp, eff_dmg);
        else            p2_cur_hp <= sat_sub(p2_cur_hp, eff_dmg);
        last_skill  <= commit_skill;
        last_damage <= eff_dmg;
        anim_cnt    <= '0;
        anim_busy   <= 1'b1;
`ifdef FIGHT_CRIT_EN
        last_crit   <= crit_hit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fight_data_control.sv
// Scoreboard bench for fight_data_control: a game-level model predicts every
// attack and KO; a monitor checks them when anim_busy / fight_over rise.
module tb_fight_data_control;
  localparam int         N    = 4;
  localparam logic [7:0] SEED = 8'h5A;

  logic       clk = 1'b0;
  logic       reset, key_U, key_D, key_C;
  logic [3:0] scene_state;
  logic [7:0] p1_pokemon_hp, p1_pokemon_speed, p2_pokemon_hp, p2_pokemon_speed;
  logic [7:0] d1 [3];
  logic [7:0] d2 [3];
  logic [7:0] p1_cur_hp, p2_cur_hp, last_damage;
  logic [1:0] p1_cursor, last_skill, winner;
  logic       turn, last_crit, anim_busy, fight_over;

  always #5 clk = ~clk;

  fight_data_control #(.ANIM_CYCLES(N), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .scene_state(scene_state),
    .key_U(key_U), .key_D(key_D), .key_C(key_C),
    .p1_pokemon_hp(p1_pokemon_hp), .p1_pokemon_speed(p1_pokemon_speed),
    .p1_skill_1_damage(d1[0]), .p1_skill_2_damage(d1[1]), .p1_skill_3_damage(d1[2]),
    .p2_pokemon_hp(p2_pokemon_hp), .p2_pokemon_speed(p2_pokemon_speed),
    .p2_skill_1_damage(d2[0]), .p2_skill_2_damage(d2[1]), .p2_skill_3_damage(d2[2]),
    .p1_cur_hp(p1_cur_hp), .p2_cur_hp(p2_cur_hp), .p1_cursor(p1_cursor),
    .turn(turn), .last_skill(last_skill), .last_damage(last_damage),
    .last_crit(last_crit), .anim_busy(anim_busy), .fight_over(fight_over),
    .winner(winner)
  );

  typedef struct { int cyc; int skill; int dmg; int crit; int h1; int h2; } atk_t;
  typedef struct { int cyc; int win; } win_t;
  atk_t atk_q[$];
  win_t win_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] m_lfsr;
  bit skip_width = 0;

  // Game-level model state
  int mh1, mh2, mcur, mwin;
  bit mturn, mover, ko_pending;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= reset ? SEED : lfsr_next(m_lfsr);
  end

  function automatic int is_crit(input logic [7:0] l);
`ifdef FIGHT_CRIT_EN
    return (l[7:5] == 3'b111) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // Monitor: pops and compares on each rising anim_busy / fight_over
  initial begin
    bit prev_busy, prev_over;
    int width;
    atk_t a;
    win_t w;
    prev_busy = 0; prev_over = 0; width = 0;
    forever begin
      @(negedge clk);
      if (anim_busy === 1'b1 && !prev_busy) begin
        width = 1;
        if (atk_q.size() == 0) chk("unexpected_attack", 1, 0);
        else begin
          a = atk_q.pop_front();
          chk("attack_cycle", cyc, a.cyc);
          chk("last_skill", last_skill, a.skill);
          chk("last_damage", last_damage, a.dmg);
          chk("last_crit", last_crit, a.crit);
          chk("p1_cur_hp", p1_cur_hp, a.h1);
          chk("p2_cur_hp", p2_cur_hp, a.h2);
        end
      end else if (anim_busy === 1'b1) width++;
      if (anim_busy === 1'b0 && prev_busy && !skip_width) chk("anim_busy_width", width, N);
      if (fight_over === 1'b1 && !prev_over) begin
        if (win_q.size() == 0) chk("unexpected_ko", 1, 0);
        else begin
          w = win_q.pop_front();
          chk("ko_cycle", cyc, w.cyc);
          chk("winner", winner, w.win);
        end
      end
      prev_busy = (anim_busy === 1'b1);
      prev_over = (fight_over === 1'b1);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_keys(input bit u, input bit d, input bit c);
    key_U = u; key_D = d; key_C = c;
  endtask

  task automatic check_reset_values();
    chk("rst_p1_hp", p1_cur_hp, 0);   chk("rst_p2_hp", p2_cur_hp, 0);
    chk("rst_cursor", p1_cursor, 1);  chk("rst_turn", turn, 0);
    chk("rst_last_skill", last_skill, 0); chk("rst_last_damage", last_damage, 0);
    chk("rst_last_crit", last_crit, 0);   chk("rst_anim_busy", anim_busy, 0);
    chk("rst_fight_over", fight_over, 0); chk("rst_winner", winner, 0);
  endtask

  // Called at the negedge of the commit cycle; predicts the hit and any KO
  task automatic commit_expect(input bit p2, input int sk);
    atk_t a;
    win_t w;
    int base, dm, cr;
    base = p2 ? int'(d2[sk-1]) : int'(d1[sk-1]);
    cr   = is_crit(m_lfsr);
    dm   = cr ? ((2 * base > 255) ? 255 : 2 * base) : base;
    if (p2) mh1 = (mh1 > dm) ? mh1 - dm : 0;
    else    mh2 = (mh2 > dm) ? mh2 - dm : 0;
    a.cyc = cyc + 1; a.skill = sk; a.dmg = dm; a.crit = cr; a.h1 = mh1; a.h2 = mh2;
    atk_q.push_back(a);
    ko_pending = p2 ? (mh1 == 0) : (mh2 == 0);
    if (ko_pending) begin
      w.cyc = cyc + N + 2; w.win = p2 ? 2 : 1;
      win_q.push_back(w);
    end
  endtask

  task automatic press(input bit u, input bit d, input bit c);
    set_keys(u, d, c);
    if (c) commit_expect(0, mcur);
    else if (u && !d) mcur = (mcur > 1) ? mcur - 1 : 1;
    else if (d && !u) mcur = (mcur < 3) ? mcur + 1 : 3;
    tick();
    set_keys(0, 0, 0);
    if (!c) chk("cursor", p1_cursor, mcur);
  endtask

  task automatic p2_turn();
    int v;
    v = int'(m_lfsr[1:0]);
    commit_expect(1, (v == 3) ? 1 : v + 1);
    tick();
  endtask

  // Entered one cycle after the commit edge; keys are noise during the animation
  task automatic resolve();
    repeat (N + 1) begin
      set_keys($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      tick();
    end
    set_keys(0, 0, 0);
    if (ko_pending) begin
      mover = 1; mwin = mturn ? 2 : 1; ko_pending = 0;
    end else begin
      mturn = !mturn;
      chk("turn_after_attack", turn, mturn);
    end
    chk("cursor_after_attack", p1_cursor, mcur);
  endtask

  task automatic start_fight(input int h1, input int s1, input int a1, input int b1, input int c1,
                             input int h2, input int s2, input int a2, input int b2, input int c2);
    p1_pokemon_hp = 8'(h1); p1_pokemon_speed = 8'(s1);
    d1[0] = 8'(a1); d1[1] = 8'(b1); d1[2] = 8'(c1);
    p2_pokemon_hp = 8'(h2); p2_pokemon_speed = 8'(s2);
    d2[0] = 8'(a2); d2[1] = 8'(b2); d2[2] = 8'(c2);
    scene_state = 4'd3;
    tick();
    tick();
    mh1 = h1; mh2 = h2; mturn = (s2 > s1); mcur = 1; mover = 0; mwin = 0; ko_pending = 0;
    chk("load_p1_hp", p1_cur_hp, mh1);   chk("load_p2_hp", p2_cur_hp, mh2);
    chk("load_turn", turn, mturn);       chk("load_cursor", p1_cursor, 1);
    chk("load_last_skill", last_skill, 0); chk("load_last_damage", last_damage, 0);
    chk("load_fight_over", fight_over, 0); chk("load_winner", winner, 0);
    chk("load_anim_busy", anim_busy, 0);
  endtask

  task automatic leave_scene();
    scene_state = 4'd1;
    tick();
    tick();
    chk("held_winner", winner, mwin);   chk("held_fight_over", fight_over, mover);
    chk("held_p1_hp", p1_cur_hp, mh1);  chk("held_p2_hp", p2_cur_hp, mh2);
    chk("held_anim_busy", anim_busy, 0);
  endtask

  task automatic play(input int max_turns);
    int turns;
    turns = 0;
    while (!mover && turns < max_turns) begin
      if (mturn) p2_turn();
      else begin
        repeat ($urandom_range(0, 3)) press($urandom_range(0, 1), $urandom_range(0, 1), 0);
        press($urandom_range(0, 1), $urandom_range(0, 1), 1);
      end
      resolve();
      turns++;
    end
  endtask

  function automatic int rnd_dmg();
    return ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; scene_state = 4'd0; set_keys(0, 0, 0);
    p1_pokemon_hp = 0; p1_pokemon_speed = 0; p2_pokemon_hp = 0; p2_pokemon_speed = 0;
    for (int i = 0; i < 3; i++) begin d1[i] = 0; d2[i] = 0; end
    tick(); tick(); tick();
    check_reset_values();
    reset = 1'b0;
    tick();

    // Cursor walk, combined-key commit, then a saturating KO by p1
    start_fight(50, 200, 30, 30, 50, 60, 150, 5, 6, 7);
    press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    press(1, 1, 0); press(0, 1, 0);
    press(0, 1, 1);
    resolve();
    p2_turn();
    resolve();
    press(0, 1, 0);
    press(0, 0, 1);
    resolve();
    repeat (4) begin
      set_keys($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      tick();
    end
    set_keys(0, 0, 0);
    chk("done_p2_hp", p2_cur_hp, 0);      chk("done_fight_over", fight_over, 1);
    chk("done_winner", winner, 1);        chk("done_cursor", p1_cursor, mcur);
    chk("done_last_skill", last_skill, 3);
    leave_scene();

    // Abort mid-animation, then reload on re-entry
    start_fight(50, 200, 30, 30, 50, 60, 150, 5, 6, 7);
    press(0, 0, 1);
    tick();
    skip_width = 1;
    scene_state = 4'd1;
    tick();
    chk("abort_anim_busy", anim_busy, 0);
    chk("abort_p2_hp", p2_cur_hp, 30);
    chk("abort_p1_hp", p1_cur_hp, 50);
    tick();
    skip_width = 0;
    start_fight(50, 200, 30, 30, 50, 60, 150, 5, 6, 7);
    leave_scene();

    // Initiative: tie goes to p1, faster p2 commits right after load
    start_fight(50, 100, 30, 30, 50, 60, 100, 5, 6, 7);
    leave_scene();
    start_fight(50, 90, 30, 30, 50, 60, 120, 5, 6, 7);
    p2_turn();
    tick();

    // Reset in the middle of an animation
    skip_width = 1;
    reset = 1'b1; scene_state = 4'd0;
    tick();
    reset = 1'b0;
    check_reset_values();
    tick();
    skip_width = 0;

    // Randomized fights
    repeat (15) begin
      start_fight($urandom_range(1, 255), $urandom_range(0, 255), rnd_dmg(), rnd_dmg(), rnd_dmg(),
                  $urandom_range(1, 255), $urandom_range(0, 255), rnd_dmg(), rnd_dmg(), rnd_dmg());
      play(30);
      leave_scene();
    end

    tick();
    chk("attack_queue_drained", atk_q.size(), 0);
    chk("ko_queue_drained", win_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
